iir_biquad_seq: RTL and testbench

Time-multiplexed Direct Form I biquad IIR section. It computes one 16-bit output sample per accepted input sample. All five coefficient products go through a single 16x16+32 multiply-add datapath, one product per cycle. The block sits in the audio filter chain between the sample source and the output stage, with valid/ready handshakes on both sides. Cascaded instances form higher-order filters.

---
 rtl/iir_pkg.sv | 33 +++
 rtl/iir_biquad_seq_if.sv | 29 ++
 rtl/multaddsub.sv | 29 ++
 rtl/iir_biquad_seq.sv | 153 +++++++++++++++
 tb/tb_iir_biquad_seq.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/iir_pkg.sv
// Shared widths, FSM state type and output saturation helper for the biquad IIR section.
package iir_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned COEF_W   = 16;
    localparam int unsigned ACC_W    = 32;
    localparam int unsigned FRAC     = 14;
    localparam int unsigned NUM_TAPS = 5;

    // Accumulator preload that turns the final arithmetic shift into round-half-up.
    localparam logic [ACC_W-1:0] ROUND_INIT = ACC_W'(1) << (FRAC - 1);

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StSat,
        StOut
    } state_e;

    function automatic logic signed [SAMPLE_W-1:0] sat_sample(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] max_v;
        logic signed [ACC_W-1:0] min_v;
        max_v = {{(ACC_W - SAMPLE_W + 1){1'b0}}, {(SAMPLE_W - 1){1'b1}}};
        min_v = {{(ACC_W - SAMPLE_W + 1){1'b1}}, {(SAMPLE_W - 1){1'b0}}};
        if (v > max_v) begin
            return max_v[SAMPLE_W-1:0];
        end else if (v < min_v) begin
            return min_v[SAMPLE_W-1:0];
        end
        return v[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/iir_biquad_seq_if.sv
// Sample-in / sample-out valid-ready handshake bundle for the biquad section.
interface iir_biquad_seq_if import iir_pkg::*; ();

    logic signed [SAMPLE_W-1:0] in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic signed [SAMPLE_W-1:0] out_data;
    logic                       out_valid;
    logic                       out_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );

endinterface

// File: rtl/multaddsub.sv
// Combinational signed multiply-accumulate: c = din +/- a*b, wrapping at ACC_WIDTH.
module multaddsub #(
    parameter int unsigned A_WIDTH   = 16,
    parameter int unsigned B_WIDTH   = 16,
    parameter int unsigned ACC_WIDTH = 32
) (
    input  logic signed [A_WIDTH-1:0]   a,
    input  logic signed [B_WIDTH-1:0]   b,
    input  logic                        sub,
    input  logic signed [ACC_WIDTH-1:0] din,
    output logic signed [ACC_WIDTH-1:0] c
);

    localparam int unsigned PW = A_WIDTH + B_WIDTH;

    logic signed [PW-1:0]        a_ext;
    logic signed [PW-1:0]        b_ext;
    logic signed [PW-1:0]        prod;
    logic signed [ACC_WIDTH-1:0] prod_acc;

    always_comb begin
        a_ext    = {{B_WIDTH{a[A_WIDTH-1]}}, a};
        b_ext    = {{A_WIDTH{b[B_WIDTH-1]}}, b};
        prod     = a_ext * b_ext;
        prod_acc = ACC_WIDTH'(prod);
        c        = sub ? (din - prod_acc) : (din + prod_acc);
    end

endmodule

// File: rtl/iir_biquad_seq.sv
// Time-multiplexed Direct Form I biquad: one shared MAC, five products per sample,
// then round, saturate and hold the result until the downstream takes it.
module iir_biquad_seq import iir_pkg::*; (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic signed [COEF_W-1:0] coef_b0,
    input  logic signed [COEF_W-1:0] coef_b1,
    input  logic signed [COEF_W-1:0] coef_b2,
    input  logic signed [COEF_W-1:0] coef_na1,
    input  logic signed [COEF_W-1:0] coef_na2,
    iir_biquad_seq_if.slave          bus
);

    state_e                     state_q, state_d;
    logic [2:0]                 step_q, step_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [SAMPLE_W-1:0] x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
    logic signed [SAMPLE_W-1:0] y1_q, y1_d, y2_q, y2_d;
    logic signed [COEF_W-1:0]   coef_q [NUM_TAPS];
    logic signed [COEF_W-1:0]   coef_d [NUM_TAPS];
    logic signed [SAMPLE_W-1:0] out_data_q, out_data_d;
    logic                       out_valid_q, out_valid_d;

    logic                       in_ready;
    logic signed [COEF_W-1:0]   op_a;
    logic signed [SAMPLE_W-1:0] op_b;
    logic signed [ACC_W-1:0]    mac_c;
    logic signed [ACC_W-1:0]    acc_shift;
    logic signed [SAMPLE_W-1:0] y_sat;

    assign in_ready      = (state_q == StIdle) && !clear && rst;
    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;

    assign acc_shift = acc_q >>> FRAC;
    assign y_sat     = sat_sample(acc_shift);

    always_comb begin
        op_a = '0;
        op_b = '0;
        unique case (step_q)
            3'd0: begin op_a = coef_q[0]; op_b = x0_q; end
            3'd1: begin op_a = coef_q[1]; op_b = x1_q; end
            3'd2: begin op_a = coef_q[2]; op_b = x2_q; end
            3'd3: begin op_a = coef_q[3]; op_b = y1_q; end
            3'd4: begin op_a = coef_q[4]; op_b = y2_q; end
            default: ;
        endcase
    end

    multaddsub #(
        .A_WIDTH  (COEF_W),
        .B_WIDTH  (SAMPLE_W),
        .ACC_WIDTH(ACC_W)
    ) u_mac (
        .a  (op_a),
        .b  (op_b),
        .sub(1'b0),
        .din(acc_q),
        .c  (mac_c)
    );

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        acc_d       = acc_q;
        x0_d        = x0_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        y1_d        = y1_q;
        y2_d        = y2_q;
        coef_d      = coef_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StIdle: begin
                if (clear) begin
                    x1_d = '0;
                    x2_d = '0;
                    y1_d = '0;
                    y2_d = '0;
                end else if (bus.in_valid && in_ready) begin
                    x0_d      = bus.in_data;
                    coef_d[0] = coef_b0;
                    coef_d[1] = coef_b1;
                    coef_d[2] = coef_b2;
                    coef_d[3] = coef_na1;
                    coef_d[4] = coef_na2;
                    acc_d     = ROUND_INIT;
                    step_d    = 3'd0;
                    state_d   = StMac;
                end
            end
            StMac: begin
                acc_d  = mac_c;
                step_d = step_q + 3'd1;
                if (step_q == 3'd4) begin
                    state_d = StSat;
                end
            end
            StSat: begin
                out_data_d  = y_sat;
                out_valid_d = 1'b1;
                x2_d        = x1_q;
                x1_d        = x0_q;
                y2_d        = y1_q;
                y1_d        = y_sat;
                state_d     = StOut;
            end
            StOut: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            step_q      <= '0;
            acc_q       <= '0;
            x0_q        <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            y1_q        <= '0;
            y2_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                coef_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            acc_q       <= acc_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            y1_q        <= y1_d;
            y2_q        <= y2_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            coef_q      <= coef_d;
        end
    end

endmodule

// File: tb/tb_iir_biquad_seq.sv
// Directed self-checking bench for iir_biquad_seq with hand-computed filter outputs.
module tb_iir_biquad_seq;
    import iir_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clear = 1'b0;
    logic signed [COEF_W-1:0] b0 = '0;
    logic signed [COEF_W-1:0] b1 = '0;
    logic signed [COEF_W-1:0] b2 = '0;
    logic signed [COEF_W-1:0] na1 = '0;
    logic signed [COEF_W-1:0] na2 = '0;

    int n_checks = 0;
    int n_err = 0;

    iir_biquad_seq_if bus ();

    always #5 clk = ~clk;

    iir_biquad_seq dut (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .coef_b0 (b0),
        .coef_b1 (b1),
        .coef_b2 (b2),
        .coef_na1(na1),
        .coef_na2(na2),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge with the DUT in IDLE; returns just after the accept edge.
    task automatic accept(input logic signed [15:0] x);
        bus.in_data  = x;
        bus.in_valid = 1'b1;
        #1;
        chk("in_ready_idle", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'sh5a5a;
    endtask

    task automatic wait_out(input string tag, input logic signed [15:0] exp_y);
        int lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 6);
        chk(tag, 32'(bus.out_data), 32'(exp_y));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "_vld_drop"}, 32'(bus.out_valid), 0);
    endtask

    task automatic sample(input string tag, input logic signed [15:0] x,
                          input logic signed [15:0] exp_y);
        accept(x);
        wait_out(tag, exp_y);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    logic signed [15:0] imp_x [6];
    logic signed [15:0] imp_y [6];

    initial begin
        imp_x = '{16'sd1000, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        imp_y = '{16'sd1000, 16'sd500, 16'sd250, 16'sd125, 16'sd63, 16'sd32};
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Pass-through; coefficient and input changes after acceptance must not matter
        b0 = 16'sd16384;
        sample("pass_1000", 16'sd1000, 16'sd1000);
        accept(-16'sd2000);
        b0 = 16'sd0;
        b1 = 16'sd9999;
        wait_out("pass_m2000", -16'sd2000);
        b0 = 16'sd16384;
        b1 = 16'sd0;

        // Round-half-up
        do_clear();
        b0 = 16'sd8192;
        sample("round_p3", 16'sd3, 16'sd2);
        sample("round_m3", -16'sd3, -16'sd1);
        sample("round_p1", 16'sd1, 16'sd1);

        // Impulse through the recursive path
        do_clear();
        b0  = 16'sd16384;
        na1 = 16'sd8192;
        for (int i = 0; i < 6; i++) begin
            sample($sformatf("imp_%0d", i), imp_x[i], imp_y[i]);
        end

        // Saturation both ways
        do_clear();
        na1 = 16'sd0;
        b0  = 16'sd32767;
        b1  = 16'sd32767;
        sample("sat_pos0", 16'sd32767, 16'sd32767);
        sample("sat_pos1", 16'sd32767, 16'sd32767);
        do_clear();
        b0 = -16'sd32767;
        b1 = -16'sd32767;
        sample("sat_neg0", 16'sd32767, -16'sd32768);
        sample("sat_neg1", 16'sd32767, -16'sd32768);

        // Backpressure: result held, nothing accepted, history intact
        do_clear();
        b0 = 16'sd16384;
        b1 = 16'sd16384;
        accept(16'sd700);
        for (int i = 0; i < 20 && bus.out_valid !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 16'sd555;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(bus.out_valid), 1);
            chk("bp_data", 32'(bus.out_data), 700);
            chk("bp_in_ready", 32'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        sample("bp_next", 16'sd100, 16'sd800);

        // Clear beats in_valid and wipes history
        do_clear();
        b1  = 16'sd0;
        na1 = 16'sd8192;
        sample("clr_pre0", 16'sd1000, 16'sd1000);
        sample("clr_pre1", 16'sd0, 16'sd500);
        clear        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'sd4000;
        #1;
        chk("clr_in_ready", 32'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("clr_no_accept", 32'(bus.out_valid), 0);
        chk("clr_idle", 32'(bus.in_ready), 1);
        for (int i = 0; i < 3; i++) begin
            sample($sformatf("clr_imp_%0d", i), imp_x[i], imp_y[i]);
        end

        // Reset during MAC step 2 aborts the sample
        accept(16'sd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_mid_in_ready_comb", 32'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        chk("rst_mid_out_valid", 32'(bus.out_valid), 0);
        chk("rst_mid_out_data", 32'(bus.out_data), 0);
        chk("rst_mid_in_ready", 32'(bus.in_ready), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rel_out_valid", 32'(bus.out_valid), 0);
        b0  = 16'sd16384;
        na1 = 16'sd8192;
        for (int i = 0; i < 4; i++) begin
            sample($sformatf("rst_imp_%0d", i), imp_x[i], imp_y[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
